// File: rtl/esteira_vinho_param.sv
// Wine-conveyor controller: fill, seal, QC, label/count and reject in one FSM,
// with cork stock, auto-refill and batch counters. Define DESCARTE_PISCA_EN to blink led_descarte.
module esteira_vinho_param #(
  parameter int ESTOQUE_MAX     = 20,
  parameter int ESTOQUE_INICIAL = 10,
  parameter int LIMIAR_ALARME   = 3,
  parameter int REFILL_QTD      = 5,
  parameter int TAM_LOTE        = 12,
  parameter int TIMEOUT_ENCH    = 50,
  parameter int DESCARTE_CICLOS = 8,
  parameter int PISCA_CICLOS    = 2,
  parameter int CNT_W           = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               btn_vedar,
  input  logic                               btn_enter_cq,
  input  logic                               btn_lacre,
  input  logic                               add_rolha,
  input  logic                               qualidade_ok,
  input  logic                               sensor_pos_ench,
  input  logic                               sensor_garrafa_cheia,
  input  logic                               sensor_pos_cq,
  input  logic                               sensor_pos_lacre,
  output logic                               motor,
  output logic                               valvula_enchimento,
  output logic                               atuador_vedacao,
  output logic                               dispensador_rolhas,
  output logic                               alarme_rolha,
  output logic                               led_descarte,
  output logic                               erro,
  output logic [3:0]                         estado,
  output logic [$clog2(ESTOQUE_MAX+1)-1:0]   estoque,
  output logic [$clog2(TAM_LOTE)-1:0]        contagem_lote,
  output logic [CNT_W-1:0]                   lotes,
  output logic [CNT_W-1:0]                   descartes
);

  localparam int EST_W  = $clog2(ESTOQUE_MAX + 1);
  localparam int LOTE_W = $clog2(TAM_LOTE);
  localparam int TMR_W  = $clog2(TIMEOUT_ENCH + 1);
  localparam int DSC_W  = $clog2(DESCARTE_CICLOS + 1);
  localparam int PSC_W  = $clog2(PISCA_CICLOS + 1);

`ifdef DESCARTE_PISCA_EN
  localparam bit PISCA_EN = 1'b1;
`else
  localparam bit PISCA_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    PARADO     = 4'd0,
    MOVE_ENCH  = 4'd1,
    ENCHENDO   = 4'd2,
    VEDANDO    = 4'd3,
    VEDA       = 4'd4,
    MOVE_CQ    = 4'd5,
    CQ         = 4'd6,
    DESCARTE   = 4'd7,
    MOVE_LACRE = 4'd8,
    LACRE      = 4'd9,
    ERRO       = 4'd10
  } state_t;

  state_t state, next_state;

  logic [4:0] levels, prev_q, edges;
  logic       edge_start, edge_vedar, edge_cq, edge_lacre, edge_add;

  logic [TMR_W-1:0] timer;
  logic [DSC_W-1:0] dsc_cnt;
  logic [PSC_W-1:0] pisca_cnt;
  logic             pisca_led;
  logic             disp_prev;
  logic             refill_fire;
  logic             stock_ok;
  logic             lote_wrap;
  int               stock_sum;
  logic [EST_W-1:0] estoque_next;

  // Rising-edge detection: a held level produces a single one-cycle edge.
  assign levels     = {add_rolha, btn_lacre, btn_enter_cq, btn_vedar, start};
  assign edges      = levels & ~prev_q;
  assign edge_start = edges[0];
  assign edge_vedar = edges[1];
  assign edge_cq    = edges[2];
  assign edge_lacre = edges[3];
  assign edge_add   = edges[4];

  assign stock_ok  = (estoque != '0);
  assign lote_wrap = (contagem_lote == LOTE_W'(TAM_LOTE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= PARADO;
      prev_q <= '0;
    end else begin
      state  <= next_state;
      prev_q <= levels;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      PARADO:     if (edge_start && stock_ok) next_state = MOVE_ENCH;
      MOVE_ENCH:  if (sensor_pos_ench) next_state = ENCHENDO;
      ENCHENDO: begin
        if (sensor_garrafa_cheia)                      next_state = VEDANDO;
        else if (timer == TMR_W'(TIMEOUT_ENCH - 1))    next_state = ERRO;
      end
      VEDANDO:    if (edge_vedar && stock_ok) next_state = VEDA;
      VEDA:       next_state = MOVE_CQ;
      MOVE_CQ:    if (sensor_pos_cq) next_state = CQ;
      CQ:         if (edge_cq) next_state = qualidade_ok ? MOVE_LACRE : DESCARTE;
      DESCARTE: begin
        if (dsc_cnt == DSC_W'(DESCARTE_CICLOS - 1))
          next_state = stock_ok ? MOVE_ENCH : PARADO;
      end
      MOVE_LACRE: if (sensor_pos_lacre) next_state = LACRE;
      LACRE:      if (edge_lacre) next_state = stock_ok ? MOVE_ENCH : PARADO;
      ERRO:       if (edge_start) next_state = PARADO;
      default:    next_state = PARADO;
    endcase
  end

  // Per-state cycle counters; they restart whenever the state is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      dsc_cnt <= '0;
    end else begin
      timer   <= (state == ENCHENDO) ? timer + 1'b1 : '0;
      dsc_cnt <= (state == DESCARTE) ? dsc_cnt + 1'b1 : '0;
    end
  end

  // Reject indicator: set on entry, optionally toggled, cleared on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pisca_cnt <= '0;
      pisca_led <= 1'b0;
    end else if (next_state == DESCARTE) begin
      if (state != DESCARTE) begin
        pisca_cnt <= '0;
        pisca_led <= 1'b1;
      end else if (pisca_cnt == PSC_W'(PISCA_CICLOS - 1)) begin
        pisca_cnt <= '0;
        if (PISCA_EN) pisca_led <= ~pisca_led;
      end else begin
        pisca_cnt <= pisca_cnt + 1'b1;
      end
    end else begin
      pisca_cnt <= '0;
      pisca_led <= 1'b0;
    end
  end

  // Auto-refill never fires in back-to-back cycles and is suppressed in ERRO.
  assign refill_fire = !reset && (state != ERRO) && !disp_prev &&
                       (estoque <= EST_W'(LIMIAR_ALARME));

  always_comb begin
    stock_sum = int'({1'b0, estoque});
    if (state == VEDA) stock_sum = stock_sum - 1;
    if (edge_add)      stock_sum = stock_sum + 1;
    if (refill_fire)   stock_sum = stock_sum + REFILL_QTD;
    if (stock_sum < 0)                stock_sum = 0;
    else if (stock_sum > ESTOQUE_MAX) stock_sum = ESTOQUE_MAX;
    estoque_next = EST_W'(stock_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estoque   <= EST_W'(ESTOQUE_INICIAL);
      disp_prev <= 1'b0;
    end else begin
      estoque   <= estoque_next;
      disp_prev <= refill_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      contagem_lote <= '0;
      lotes         <= '0;
      descartes     <= '0;
    end else begin
      if (state == LACRE && edge_lacre) begin
        if (lote_wrap) begin
          contagem_lote <= '0;
          lotes         <= lotes + 1'b1;
        end else begin
          contagem_lote <= contagem_lote + 1'b1;
        end
      end
      if (state == CQ && edge_cq && !qualidade_ok)
        descartes <= descartes + 1'b1;
    end
  end

  assign estado             = state;
  assign motor              = (state == MOVE_ENCH) || (state == MOVE_CQ) || (state == MOVE_LACRE);
  assign valvula_enchimento = (state == ENCHENDO);
  assign atuador_vedacao    = (state == VEDA);
  assign erro               = (state == ERRO);
  assign led_descarte       = pisca_led;
  assign dispensador_rolhas = refill_fire;
  assign alarme_rolha       = (estoque <= EST_W'(LIMIAR_ALARME));

endmodule

// File: tb/tb_esteira_vinho_param.sv
// Self-checking bench for esteira_vinho_param: scoreboard of expected state and
// counter values, plus a per-cycle monitor of the state-decoded outputs.
module tb_esteira_vinho_param;

  logic clk = 1'b0;
  logic reset, start, btn_vedar, btn_enter_cq, btn_lacre, add_rolha, qualidade_ok;
  logic sensor_pos_ench, sensor_garrafa_cheia, sensor_pos_cq, sensor_pos_lacre;
  logic motor, valvula_enchimento, atuador_vedacao, dispensador_rolhas;
  logic alarme_rolha, led_descarte, erro;
  logic [3:0] estado;
  logic [4:0] estoque;
  logic [3:0] contagem_lote;
  logic [7:0] lotes, descartes;

  always #5 clk = ~clk;

  esteira_vinho_param dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .btn_vedar            (btn_vedar),
    .btn_enter_cq         (btn_enter_cq),
    .btn_lacre            (btn_lacre),
    .add_rolha            (add_rolha),
    .qualidade_ok         (qualidade_ok),
    .sensor_pos_ench      (sensor_pos_ench),
    .sensor_garrafa_cheia (sensor_garrafa_cheia),
    .sensor_pos_cq        (sensor_pos_cq),
    .sensor_pos_lacre     (sensor_pos_lacre),
    .motor                (motor),
    .valvula_enchimento   (valvula_enchimento),
    .atuador_vedacao      (atuador_vedacao),
    .dispensador_rolhas   (dispensador_rolhas),
    .alarme_rolha         (alarme_rolha),
    .led_descarte         (led_descarte),
    .erro                 (erro),
    .estado               (estado),
    .estoque              (estoque),
    .contagem_lote        (contagem_lote),
    .lotes                (lotes),
    .descartes            (descartes)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    check("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side model of stock and counters.
  int est_m, cont_m, lotes_m, desc_m, exp_disp, disp_seen;
  bit mon_en = 1'b0;
  bit disp_prev_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("motor_dec", motor, (estado == 4'd1) || (estado == 4'd5) || (estado == 4'd8));
      check("valvula_dec", valvula_enchimento, estado == 4'd2);
      check("atuador_dec", atuador_vedacao, estado == 4'd4);
      check("erro_dec", erro, estado == 4'd10);
      check("alarme_dec", alarme_rolha, estoque <= 5'd3);
`ifndef DESCARTE_PISCA_EN
      check("led_dec", led_descarte, estado == 4'd7);
`endif
      check("disp_single", disp_prev_seen && dispensador_rolhas, 0);
      if (dispensador_rolhas) disp_seen++;
      disp_prev_seen = dispensador_rolhas;
    end
  end

  function automatic logic led_exp(input int i);
`ifdef DESCARTE_PISCA_EN
    return ((i / 2) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic press_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic run_bottle(input bit qok);
    if (estado == 4'd0) begin
      sb_push("start_to_move_ench", 1);
      start = 1'b1;
      tick();
      sb_pop(estado);
      start = 1'b0;
      tick();
    end
    sb_push("pos_ench_to_enchendo", 2);
    sensor_pos_ench = 1'b1;
    tick();
    sb_pop(estado);
    sensor_pos_ench = 1'b0;

    sb_push("cheia_to_vedando", 3);
    sensor_garrafa_cheia = 1'b1;
    tick();
    sb_pop(estado);
    sensor_garrafa_cheia = 1'b0;

    sb_push("vedar_to_veda", 4);
    btn_vedar = 1'b1;
    tick();
    sb_pop(estado);
    btn_vedar = 1'b0;

    est_m--;
    sb_push("veda_to_move_cq", 5);
    sb_push("estoque_after_seal", est_m);
    tick();
    sb_pop(estado);
    sb_pop(estoque);
    if (est_m <= 3) begin
      check("alarme_low", alarme_rolha, 1);
      check("disp_pulse", dispensador_rolhas, 1);
      est_m = (est_m + 5 > 20) ? 20 : est_m + 5;
      exp_disp++;
      tick();
      check("estoque_refill", estoque, est_m);
      check("disp_after", dispensador_rolhas, 0);
      check("alarme_clear", alarme_rolha, 0);
    end

    sb_push("pos_cq_to_cq", 6);
    sensor_pos_cq = 1'b1;
    tick();
    sb_pop(estado);
    sensor_pos_cq = 1'b0;

    qualidade_ok = qok;
    sb_push("cq_decision", qok ? 8 : 7);
    btn_enter_cq = 1'b1;
    tick();
    sb_pop(estado);
    btn_enter_cq = 1'b0;

    if (!qok) begin
      desc_m++;
      check("descartes_inc", descartes, desc_m);
      for (int i = 0; i < 8; i++) begin
        if (i > 0) tick();
        check("descarte_hold", estado, 7);
        check("led_pattern", led_descarte, led_exp(i));
      end
      tick();
      check("descarte_exit", estado, 1);
      check("led_off_exit", led_descarte, 0);
    end else begin
      tick();
      check("move_lacre_wait", estado, 8);
      sb_push("pos_lacre_to_lacre", 9);
      sensor_pos_lacre = 1'b1;
      tick();
      sb_pop(estado);
      sensor_pos_lacre = 1'b0;
      if (cont_m == 11) begin
        cont_m = 0;
        lotes_m++;
      end else begin
        cont_m++;
      end
      sb_push("lacre_to_move_ench", 1);
      sb_push("contagem_lote", cont_m);
      sb_push("lotes", lotes_m);
      btn_lacre = 1'b1;
      tick();
      sb_pop(estado);
      sb_pop(contagem_lote);
      sb_pop(lotes);
      btn_lacre = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    {start, btn_vedar, btn_enter_cq, btn_lacre, add_rolha, qualidade_ok} = '0;
    {sensor_pos_ench, sensor_garrafa_cheia, sensor_pos_cq, sensor_pos_lacre} = '0;
    est_m = 10; cont_m = 0; lotes_m = 0; desc_m = 0; exp_disp = 0; disp_seen = 0;

    repeat (2) tick();
    reset = 1'b0;
    check("rst_estado", estado, 0);
    check("rst_estoque", estoque, 10);
    check("rst_contagem", contagem_lote, 0);
    check("rst_lotes", lotes, 0);
    check("rst_descartes", descartes, 0);
    check("rst_disp", dispensador_rolhas, 0);
    check("rst_motor", motor, 0);
    mon_en = 1'b1;

    // Happy path, then the rest of a full batch.
    run_bottle(1'b1);
    check("happy_estoque", estoque, 9);
    check("happy_contagem", contagem_lote, 1);
    for (int b = 1; b < 12; b++) run_bottle(1'b1);
    check("batch_contagem", contagem_lote, 0);
    check("batch_lotes", lotes, 1);

    // Reject path.
    run_bottle(1'b0);
    check("reject_descartes", descartes, 1);
    check("reject_contagem", contagem_lote, 0);
    check("disp_count", disp_seen, exp_disp);

    // Held manual add counts once.
    add_rolha = 1'b1;
    repeat (10) tick();
    add_rolha = 1'b0;
    tick();
    est_m++;
    check("add_held_once", estoque, est_m);

    // Saturation at the stock ceiling.
    for (int k = 0; k < 15; k++) begin
      add_rolha = 1'b1;
      tick();
      add_rolha = 1'b0;
      tick();
    end
    check("estoque_sat", estoque, 20);

    // Fill timeout.
    check("pre_timeout_state", estado, 1);
    sensor_pos_ench = 1'b1;
    tick();
    sensor_pos_ench = 1'b0;
    n = 1;
    while (estado == 4'd2 && n < 200) begin
      tick();
      if (estado == 4'd2) n++;
    end
    check("timeout_cycles", n, 50);
    check("timeout_estado", estado, 10);
    check("timeout_valvula", valvula_enchimento, 0);
    check("timeout_erro", erro, 1);
    check("erro_lotes_held", lotes, 1);
    check("erro_desc_held", descartes, 1);
    check("erro_estoque_held", estoque, 20);
    press_start();
    check("erro_to_parado", estado, 0);
    check("erro_cleared", erro, 0);

    // Bottle-full wins over timeout in the last fill cycle.
    press_start();
    check("restart_move", estado, 1);
    sensor_pos_ench = 1'b1;
    tick();
    sensor_pos_ench = 1'b0;
    repeat (49) tick();
    check("ench_last_cycle", estado, 2);
    sensor_garrafa_cheia = 1'b1;
    tick();
    sensor_garrafa_cheia = 1'b0;
    check("cheia_priority", estado, 3);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_from_vedando", estado, 0);

    // Reset during fill.
    press_start();
    sensor_pos_ench = 1'b1;
    tick();
    sensor_pos_ench = 1'b0;
    check("midfill_enchendo", estado, 2);
    reset = 1'b1;
    tick();
    check("midfill_estado", estado, 0);
    check("midfill_valvula", valvula_enchimento, 0);
    check("midfill_estoque", estoque, 10);
    check("midfill_contagem", contagem_lote, 0);
    check("midfill_lotes", lotes, 0);
    check("midfill_descartes", descartes, 0);
    reset = 1'b0;
    tick();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
